// File: rtl/data_read_initiator_pkg.sv
// Shared types for the data storage interface: request/return records, initiator tags,
// request_id field helpers and the per-tag tracking entry.
package data_read_initiator_pkg;

   localparam int ContextThreadLength = 4;

   localparam int ADDR_W       = 16;
   localparam int RECV_W       = 6;
   localparam int DATA_W       = 32;
   localparam int INIT_FIELD_W = 4;
   localparam int TAG_FIELD_W  = 4;
   localparam int REQ_ID_W     = INIT_FIELD_W + TAG_FIELD_W;
   localparam int AGE_W        = 16;

   typedef logic [ADDR_W-1:0]       address_t;
   typedef logic [RECV_W-1:0]       receive_id_t;
   typedef logic [REQ_ID_W-1:0]     request_id_t;
   typedef logic [INIT_FIELD_W-1:0] init_id_t;
   typedef logic [TAG_FIELD_W-1:0]  init_tag_t;

   typedef union packed {
      logic [DATA_W-1:0]   word;
      logic [1:0][15:0]    half;
   } data_register_union_t;

   typedef struct packed {
      logic                 valid;
      request_id_t          request_id;
      receive_id_t          receive_id;
      address_t             read_address;
   } read_request_t;

   typedef struct packed {
      logic                 valid;
      address_t             write_address;
      data_register_union_t data;
   } write_request_t;

   typedef struct packed {
      logic                 valid;
      request_id_t          request_id;
      receive_id_t          receive_id;
      data_register_union_t data;
   } read_return_t;

   typedef enum logic {
      TAG_FREE   = 1'b0,
      TAG_ISSUED = 1'b1
   } tag_state_e;

   typedef struct packed {
      tag_state_e           state;
      receive_id_t          receive_id;
      address_t             address;
      logic [AGE_W-1:0]     age;
   } tag_entry_t;

   function automatic init_id_t req_initiator(input request_id_t id);
      return id[REQ_ID_W-1 -: INIT_FIELD_W];
   endfunction

   function automatic init_tag_t req_tag(input request_id_t id);
      return id[TAG_FIELD_W-1:0];
   endfunction

   function automatic request_id_t make_request_id(input init_id_t init, input init_tag_t tag);
      return {init, tag};
   endfunction

endpackage

// File: rtl/data_read_initiator_tag_allocator.sv
// Busy bitmap for outstanding load tags: lowest-free priority encode and free-on-return.
module tag_allocator #(
   parameter int NUM_TAGS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alloc,
   input  logic                        free_en,
   input  logic [$clog2(NUM_TAGS)-1:0] free_idx,
   output logic [NUM_TAGS-1:0]         busy,
   output logic                        any_free,
   output logic [$clog2(NUM_TAGS)-1:0] alloc_idx
);

   localparam int TAG_W = $clog2(NUM_TAGS);

   always_comb begin
      alloc_idx = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!busy[i]) alloc_idx = TAG_W'(i);
      end
   end

   assign any_free = ~&busy;

   // free_idx is always a busy tag and alloc_idx a free one, so the two never collide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (free_en) busy[free_idx]  <= 1'b0;
         if (alloc)   busy[alloc_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/data_read_initiator.sv
// Issues loads/stores to the data storage responder, tracks loads by tag and routes returns
// back to the issuing thread register; stores wait behind any in-flight load to the same address.
//
// tag state  | meaning
// TAG_FREE   | tag unused, may be allocated to the next accepted load
// TAG_ISSUED | read sent, waiting for its return; age counts up to TIMEOUT_CYCLES
module data_read_initiator
   import data_read_initiator_pkg::*;
#(
   parameter int NUM_TAGS       = 8,
   parameter int QUEUE_CREDITS  = ContextThreadLength * 2,
   parameter int INITIATOR_ID   = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_is_store,
   input  address_t                  cmd_address,
   input  data_register_union_t      cmd_data,
   input  receive_id_t               cmd_receive_id,
   output read_request_t             read_req,
   output write_request_t            write_req,
   input  read_return_t              read_back,
   output logic                      wb_valid,
   output receive_id_t               wb_receive_id,
   output data_register_union_t      wb_data,
   output logic [$clog2(NUM_TAGS):0] outstanding,
   output logic                      err_timeout,
   output logic                      err_spurious
);

   localparam int TAG_W  = $clog2(NUM_TAGS);
   localparam int CNT_W  = $clog2(NUM_TAGS) + 1;
   localparam int CRED_W = $clog2(QUEUE_CREDITS + 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT_CYCLES);

   tag_entry_t          entries   [NUM_TAGS];
   tag_entry_t          entries_n [NUM_TAGS];
   logic [NUM_TAGS-1:0] busy;
   logic [NUM_TAGS-1:0] timeout_hit;
   logic                any_free;
   logic [TAG_W-1:0]    alloc_idx;
   logic [CRED_W-1:0]   credits;
   logic [CRED_W-1:0]   credits_n;
   logic [CNT_W-1:0]    busy_count;
   logic                addr_conflict;
   logic                load_acc;
   logic                store_acc;
   logic                ret_ours;
   logic                ret_hit;
   logic                credit_over;
   init_tag_t           ret_tag;
   logic [TAG_W-1:0]    ret_idx;
   logic                unused_ret_rid;

   tag_allocator #(.NUM_TAGS(NUM_TAGS)) u_tag_allocator (
      .clk       (clk),
      .rst       (rst),
      .alloc     (load_acc),
      .free_en   (ret_hit),
      .free_idx  (ret_idx),
      .busy      (busy),
      .any_free  (any_free),
      .alloc_idx (alloc_idx)
   );

   always_comb begin
      addr_conflict = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (busy[i] && entries[i].address == cmd_address) addr_conflict = 1'b1;
      end
   end

   assign cmd_ready = !rst && (cmd_is_store ? !addr_conflict : (any_free && credits != '0));
   assign load_acc  = cmd_valid && cmd_ready && !cmd_is_store;
   assign store_acc = cmd_valid && cmd_ready && cmd_is_store;

   // the responder's echoed receive_id is not trusted; the stored copy is used
   assign unused_ret_rid = ^read_back.receive_id;
   assign ret_ours    = read_back.valid &&
                        (req_initiator(read_back.request_id) == init_id_t'(INITIATOR_ID));
   assign ret_tag     = req_tag(read_back.request_id);
   assign ret_idx     = ret_tag[TAG_W-1:0];
   assign ret_hit     = ret_ours && (int'(ret_tag) < NUM_TAGS) && busy[ret_idx];
   assign credit_over = ret_hit && !load_acc && (credits == CRED_W'(QUEUE_CREDITS));

   always_comb begin
      credits_n = credits;
      if (load_acc && !ret_hit)                     credits_n = credits - CRED_W'(1);
      else if (ret_hit && !load_acc && !credit_over) credits_n = credits + CRED_W'(1);
   end

   always_comb begin
      timeout_hit = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         entries_n[i] = entries[i];
         case (entries[i].state)
            TAG_ISSUED: begin
               if (ret_hit && ret_idx == TAG_W'(i)) begin
                  entries_n[i].state = TAG_FREE;
                  entries_n[i].age   = '0;
               end else if (entries[i].age != AGE_LIMIT) begin
                  entries_n[i].age = entries[i].age + AGE_W'(1);
                  if (entries[i].age == AGE_LIMIT - AGE_W'(1)) timeout_hit[i] = 1'b1;
               end
            end
            default: begin
               if (load_acc && alloc_idx == TAG_W'(i)) begin
                  entries_n[i].state      = TAG_ISSUED;
                  entries_n[i].receive_id = cmd_receive_id;
                  entries_n[i].address    = cmd_address;
                  entries_n[i].age        = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      busy_count = '0;
      for (int i = 0; i < NUM_TAGS; i++) busy_count = busy_count + CNT_W'(busy[i]);
   end
   assign outstanding = busy_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            entries[i].state      <= TAG_FREE;
            entries[i].receive_id <= '0;
            entries[i].address    <= '0;
            entries[i].age        <= '0;
         end
         credits       <= CRED_W'(QUEUE_CREDITS);
         read_req      <= '0;
         write_req     <= '0;
         wb_valid      <= 1'b0;
         wb_receive_id <= '0;
         wb_data       <= '0;
         err_timeout   <= 1'b0;
         err_spurious  <= 1'b0;
      end else begin
         entries <= entries_n;
         credits <= credits_n;
         if (load_acc) begin
            read_req <= '{valid:        1'b1,
                          request_id:   make_request_id(init_id_t'(INITIATOR_ID), init_tag_t'(alloc_idx)),
                          receive_id:   cmd_receive_id,
                          read_address: cmd_address};
         end else begin
            read_req <= '0;
         end
         if (store_acc) write_req <= '{valid: 1'b1, write_address: cmd_address, data: cmd_data};
         else           write_req <= '0;
         wb_valid      <= ret_hit;
         wb_receive_id <= ret_hit ? entries[ret_idx].receive_id : '0;
         wb_data       <= ret_hit ? read_back.data : '0;
         err_timeout   <= err_timeout | (|timeout_hit);
         err_spurious  <= err_spurious | (ret_ours && !ret_hit) | credit_over;
      end
   end

endmodule

// File: tb/tb_data_read_initiator.sv
// Self-checking bench: dut_a uses default parameters, dut_b has 2 credits and a 16-cycle timeout.
module tb_data_read_initiator;
   import data_read_initiator_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                 cmd_valid, cmd_is_store;
   address_t             cmd_address;
   data_register_union_t cmd_data;
   receive_id_t          cmd_receive_id;
   read_return_t         read_back;

   logic rdy_a, wb_valid_a, err_to_a, err_sp_a;
   logic rdy_b, wb_valid_b, err_to_b, err_sp_b;
   read_request_t rq_a, rq_b;
   write_request_t wr_a, wr_b;
   receive_id_t wb_rid_a, wb_rid_b;
   data_register_union_t wb_data_a, wb_data_b;
   logic [3:0] out_a, out_b;

   data_read_initiator dut_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_a), .cmd_is_store(cmd_is_store),
      .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_receive_id(cmd_receive_id),
      .read_req(rq_a), .write_req(wr_a), .read_back(read_back), .wb_valid(wb_valid_a),
      .wb_receive_id(wb_rid_a), .wb_data(wb_data_a), .outstanding(out_a),
      .err_timeout(err_to_a), .err_spurious(err_sp_a));

   data_read_initiator #(.QUEUE_CREDITS(2), .TIMEOUT_CYCLES(16)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_b), .cmd_is_store(cmd_is_store),
      .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_receive_id(cmd_receive_id),
      .read_req(rq_b), .write_req(wr_b), .read_back(read_back), .wb_valid(wb_valid_b),
      .wb_receive_id(wb_rid_b), .wb_data(wb_data_b), .outstanding(out_b),
      .err_timeout(err_to_b), .err_spurious(err_sp_b));

   typedef struct packed { request_id_t id; receive_id_t rid; address_t addr; } rq_exp_t;
   typedef struct packed { receive_id_t rid; logic [31:0] data; } wb_exp_t;
   typedef struct packed { address_t addr; logic [31:0] data; } wr_exp_t;
   typedef struct { address_t addr; receive_id_t rid; logic [31:0] data; int exp_tag; logic [3:0] exp_out; } vec_t;

   rq_exp_t rq_q[$];
   wb_exp_t wb_q[$];
   wr_exp_t wr_q[$];
   rq_exp_t rq_e;
   wb_exp_t wb_e;
   wr_exp_t wr_e;
   vec_t    vecs[4];

   int checks = 0;
   int errors = 0;
   bit sb_en  = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: pop the expectation pushed when the stimulus was driven
   always @(posedge clk) begin
      #1;
      if (sb_en && !rst) begin
         if (rq_a.valid) begin
            if (rq_q.size() == 0) chk("read_req_unexpected", 128'(rq_a.request_id), 128'hFFFF);
            else begin
               rq_e = rq_q.pop_front();
               chk("read_req_id", 128'(rq_a.request_id), 128'(rq_e.id));
               chk("read_req_rid", 128'(rq_a.receive_id), 128'(rq_e.rid));
               chk("read_req_addr", 128'(rq_a.read_address), 128'(rq_e.addr));
            end
         end
         if (wb_valid_a) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 128'(wb_rid_a), 128'hFFFF);
            else begin
               wb_e = wb_q.pop_front();
               chk("wb_rid", 128'(wb_rid_a), 128'(wb_e.rid));
               chk("wb_data", 128'(wb_data_a.word), 128'(wb_e.data));
            end
         end
         if (wr_a.valid) begin
            if (wr_q.size() == 0) chk("write_unexpected", 128'(wr_a.write_address), 128'hFFFFF);
            else begin
               wr_e = wr_q.pop_front();
               chk("write_addr", 128'(wr_a.write_address), 128'(wr_e.addr));
               chk("write_data", 128'(wr_a.data.word), 128'(wr_e.data));
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cmd_valid = 1'b0;
      read_back = '0;
      rq_q.delete(); wb_q.delete(); wr_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue(input bit which, input bit st, input address_t a, input logic [31:0] d,
                        input receive_id_t r, input int tag, input int budget);
      bit done;
      done = 1'b0;
      if (!which) begin
         if (st) wr_q.push_back('{addr: a, data: d});
         else    rq_q.push_back('{id: {4'h0, 4'(tag)}, rid: r, addr: a});
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_is_store = st; cmd_address = a; cmd_data.word = d; cmd_receive_id = r;
      for (int i = 0; i < budget && !done; i++) begin
         #1;
         if ((which ? rdy_b : rdy_a) == 1'b1) done = 1'b1;
         @(posedge clk);
         if (!done) @(negedge clk);
      end
      #1;
      cmd_valid = 1'b0;
      chk("cmd_accept", 128'(done), 128'(1));
   endtask

   task automatic send_ret(input logic [3:0] init, input logic [3:0] tag, input receive_id_t rid,
                           input logic [31:0] d);
      @(negedge clk);
      read_back.valid = 1'b1;
      read_back.request_id = {init, tag};
      read_back.receive_id = rid;
      read_back.data.word = d;
      @(posedge clk);
      #1;
      read_back = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      cmd_valid = 1'b0; cmd_is_store = 1'b0; cmd_address = '0; cmd_data = '0;
      cmd_receive_id = '0; read_back = '0;

      vecs[0] = '{16'h0010, 6'd3,  32'h0000ABCD, 0, 4'd1};
      vecs[1] = '{16'h1234, 6'h3F, 32'hFFFFFFFF, 0, 4'd1};
      vecs[2] = '{16'h0000, 6'd0,  32'h00000001, 0, 4'd1};
      vecs[3] = '{16'hFFFF, 6'h15, 32'hDEADBEEF, 0, 4'd1};

      // reset state
      @(posedge clk); #1;
      chk("rst_cmd_ready", rdy_a, 1'b0);
      chk("rst_read_req", rq_a, '0);
      chk("rst_write_req", wr_a, '0);
      chk("rst_wb", {wb_valid_a, wb_rid_a, wb_data_a}, '0);
      chk("rst_outstanding", out_a, 4'd0);
      chk("rst_errs", {err_to_a, err_sp_a}, 2'b00);
      chk("rst_b_outputs", |{rdy_b, rq_b, wr_b, wb_valid_b, wb_rid_b, wb_data_b, out_b, err_to_b, err_sp_b}, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", rdy_a, 1'b1);

      // single load/return transactions
      sb_en = 1'b1;
      for (int v = 0; v < 4; v++) begin
         issue(1'b0, 1'b0, vecs[v].addr, 32'h0, vecs[v].rid, vecs[v].exp_tag, 2);
         chk("tbl_outstanding_load", out_a, vecs[v].exp_out);
         wb_q.push_back('{rid: vecs[v].rid, data: vecs[v].data});
         send_ret(4'h0, 4'(vecs[v].exp_tag), vecs[v].rid ^ 6'h2A, vecs[v].data);
         chk("tbl_outstanding_ret", out_a, 4'd0);
      end

      // fill all tags, then free tag 5 and reuse it
      do_reset();
      for (int i = 0; i < 8; i++) issue(1'b0, 1'b0, 16'h0100 + 16'(i), 32'h0, 6'(i + 8), i, 1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_address = 16'h0200;
      #1;
      chk("ninth_held", rdy_a, 1'b0);
      chk("full_outstanding", out_a, 4'd8);
      @(negedge clk);
      wb_q.push_back('{rid: 6'd13, data: 32'h55555555});
      read_back.valid = 1'b1; read_back.request_id = 8'h05; read_back.receive_id = 6'd0;
      read_back.data.word = 32'h55555555;
      #1;
      chk("freed_tag_not_same_cycle", rdy_a, 1'b0);
      @(posedge clk); #1;
      cmd_valid = 1'b0; read_back = '0;
      chk("after_free_outstanding", out_a, 4'd7);
      issue(1'b0, 1'b0, 16'h0300, 32'h0, 6'd20, 5, 1);
      chk("refill_outstanding", out_a, 4'd8);

      // store ordering behind a load to the same address
      do_reset();
      issue(1'b0, 1'b0, 16'h0020, 32'h0, 6'd4, 0, 1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_is_store = 1'b1; cmd_address = 16'h0020; cmd_data.word = 32'h1111;
      #1;
      chk("store_conflict", rdy_a, 1'b0);
      @(negedge clk); #1;
      chk("store_conflict_hold", rdy_a, 1'b0);
      cmd_valid = 1'b0;
      issue(1'b0, 1'b1, 16'h0021, 32'h2222, 6'd0, 0, 1);
      wb_q.push_back('{rid: 6'd4, data: 32'h3333});
      send_ret(4'h0, 4'h0, 6'd9, 32'h3333);
      issue(1'b0, 1'b1, 16'h0020, 32'h1111, 6'd0, 0, 1);

      // foreign and spurious returns
      do_reset();
      issue(1'b0, 1'b0, 16'h0040, 32'h0, 6'd2, 0, 1);
      send_ret(4'h1, 4'h0, 6'd2, 32'h9999);
      chk("foreign_no_err", err_sp_a, 1'b0);
      chk("foreign_outstanding", out_a, 4'd1);
      send_ret(4'h0, 4'h3, 6'd2, 32'h8888);
      chk("spurious_set", err_sp_a, 1'b1);
      chk("spurious_outstanding", out_a, 4'd1);
      wb_q.push_back('{rid: 6'd2, data: 32'h7777});
      send_ret(4'h0, 4'h0, 6'd2, 32'h7777);
      chk("spurious_sticky", err_sp_a, 1'b1);
      chk("spurious_final_out", out_a, 4'd0);
      @(negedge clk);
      chk("queues_empty", rq_q.size() + wb_q.size() + wr_q.size(), 0);

      // credit limit on dut_b
      sb_en = 1'b0;
      do_reset();
      issue(1'b1, 1'b0, 16'h0030, 32'h0, 6'd1, 0, 1);
      issue(1'b1, 1'b0, 16'h0031, 32'h0, 6'd2, 1, 1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_address = 16'h0032;
      #1;
      chk("credit_hold", rdy_b, 1'b0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      send_ret(4'h0, 4'h0, 6'd1, 32'h1);
      chk("credit_returned", rdy_b, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_address = 16'h0033;
      read_back.valid = 1'b1; read_back.request_id = 8'h01; read_back.data.word = 32'h2;
      #1;
      chk("same_cycle_ready", rdy_b, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; read_back = '0;
      chk("same_cycle_outstanding", out_b, 4'd1);
      chk("same_cycle_credits_net", rdy_b, 1'b1);
      issue(1'b1, 1'b0, 16'h0034, 32'h0, 6'd3, 1, 1);
      chk("credits_exhausted", rdy_b, 1'b0);
      chk("credits_exhausted_out", out_b, 4'd2);

      // timeout and async reset on dut_b
      do_reset();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_address = 16'h0050; cmd_receive_id = 6'd5;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("to_read_req", rq_b.valid, 1'b1);
      repeat (15) @(posedge clk);
      #1;
      chk("to_before_limit", err_to_b, 1'b0);
      @(posedge clk); #1;
      chk("to_at_limit", err_to_b, 1'b1);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_rst_to", err_to_b, 1'b0);
      chk("async_rst_out", out_b, 4'd0);
      chk("async_rst_ready", rdy_b, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_no_spur", err_sp_b, 1'b0);
      send_ret(4'h0, 4'h0, 6'd5, 32'h77);
      chk("pre_rst_tag_spur", err_sp_b, 1'b1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
